module_barrido_teclado: RTL
===========================

Name: module_barrido_teclado

Overview:
- Active column-scan driver and key encoder for the 4x4 matrix keypad. It is the drive side of the row interface that module_teclado samples.
- Drives one-hot columns and reads the returned rows (active-high, as on the fila bus). It debounces both press and release.
- Emits a 4-bit hex key code with a single-cycle valid strobe.
- Feeds the operand-loading logic in place of raw row sampling.

Parameters:
SETTLE_CYCLES, 4, cycles a column is driven before rows are sampled (min 1)
DEBOUNCE_CYCLES, 8, consecutive stable cycles required to accept a press or a release (min 1)
REPEAT_CYCLES, 1000, auto-repeat period while a key is held (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
fila  in  4  keypad rows, active-high, asynchronous to clk
columna  out  4  one-hot active-high column drive
tecla  out  4  hex code of the last accepted key
tecla_valida  out  1  one-cycle strobe, asserted when tecla updates
ocupado  out  1  high from press detection until release is accepted

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: columna=4'b0001, tecla=4'h0, tecla_valida=0, ocupado=0, col_idx=0, counters=0, state=SCAN, synchronizer flops=0.
- Synchronizer: fila passes through a 2-flop synchronizer to fila_s. All decisions use fila_s only.
- Column drive: columna = 4'b0001 << col_idx. It is registered and changes only when col_idx changes.
- State SCAN:
  - cnt increments each cycle.
  - At cnt==SETTLE_CYCLES-1, sample fila_s.
  - If fila_s==0: col_idx advances (3 wraps to 0), cnt=0.
  - Otherwise: latch row_idx = lowest set bit of fila_s (priority row0 > row3), cnt=0, ocupado=1, go to DEB_PRESS.
- State DEB_PRESS (column held):
  - If fila_s[row_idx]==1, cnt increments.
  - At cnt==DEBOUNCE_CYCLES-1 with the bit still high, go to HOLD.
  - In that same transition cycle, tecla is registered and tecla_valida=1 on the next cycle, coincident with the new tecla value.
  - If fila_s[row_idx]==0 at any cycle: ocupado=0, cnt=0, return to SCAN on the same column. No strobe.
- Key map, row-major by {row_idx, col_idx}:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- State HOLD (column held):
  - Any fila_s!=0 clears cnt.
  - fila_s==0 increments cnt.
  - At cnt==DEBOUNCE_CYCLES-1, release is accepted: ocupado=0, cnt=0, col_idx advances, go to SCAN.
- tecla_valida: exactly one cycle per accepted press.
- Second key while holding: a second key pressed while a first is held is ignored until full release. This includes a different row on the same column.
- tecla hold: tecla retains its value until the next accepted press.
- Mid-operation reset: rst in any state restores all reset values next cycle. A pending press produces no strobe.
- Counter width: $clog2 of max(SETTLE_CYCLES, DEBOUNCE_CYCLES, REPEAT_CYCLES)+1. Counters never wrap.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In HOLD, a separate repeat counter runs while fila_s[row_idx]==1.
  - Every REPEAT_CYCLES cycles of continuous hold, tecla_valida pulses once with tecla unchanged.
  - The repeat counter clears when the bit drops and on state entry.
- Undefined: the repeat counter logic is absent. Exactly one strobe per press.

Test Plan:
1. Reset, fila=0, SETTLE_CYCLES=2: columna cycles 0001→0010→0100→1000→0001, each column held 2 cycles. tecla_valida stays 0.
2. Press row1/col2 cleanly (fila=0010 only while columna=0100), DEBOUNCE_CYCLES=4: after sync+settle+4 cycles, a single tecla_valida with tecla=4'h6. ocupado=1 and columna frozen at 0100 until release.
3. Bouncy press (0010/0000 toggling every 1-2 cycles, then stable): no strobe during bounce. Exactly one strobe with tecla=4'h6 once stable ≥4 cycles.
4. Release with bounce (0000/0010 alternating, then 0000): scanning stays frozen until 4 consecutive zero cycles. Then ocupado=0 and columna advances to 1000.
5. Rows 0 and 3 both high on col0: tecla=4'h1 (row0 priority). Only one strobe. A second press during HOLD produces no strobe.
6. Assert rst during DEB_PRESS: next cycle columna=0001, ocupado=0, no strobe. With KEY_REPEAT_EN and REPEAT_CYCLES=10, holding key 'A' gives a strobe every 10 cycles with tecla=4'hA.

Source files
------------

// File: rtl/module_barrido_teclado.sv
// rtl/module_barrido_teclado.sv - 4x4 keypad column scanner with debounced press/release and hex key encoding
// Define KEY_REPEAT_EN to re-strobe tecla_valida every REPEAT_CYCLES while a key stays held.
module module_barrido_teclado #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [3:0] columna,
    output logic [3:0] tecla,
    output logic       tecla_valida,
    output logic       ocupado
);
    localparam int MAX_SD = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int MAX_C  = (MAX_SD > REPEAT_CYCLES) ? MAX_SD : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HOLD
    } state_t;

    state_t        state;
    logic [3:0]    fila_m;
    logic [3:0]    fila_s;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [1:0]    col_next;
    logic [1:0]    first_row;
    logic          row_bit;
    logic [CW-1:0] cnt;

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] rep_cnt;
`endif

    // Row-major key layout indexed by {row, column}.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    always_comb begin
        first_row = 2'd0;
        if (fila_s[0])      first_row = 2'd0;
        else if (fila_s[1]) first_row = 2'd1;
        else if (fila_s[2]) first_row = 2'd2;
        else if (fila_s[3]) first_row = 2'd3;
    end

    assign row_bit  = fila_s[row_idx];
    assign col_next = col_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            fila_m       <= 4'b0;
            fila_s       <= 4'b0;
            state        <= SCAN;
            col_idx      <= 2'd0;
            row_idx      <= 2'd0;
            cnt          <= '0;
            columna      <= 4'b0001;
            tecla        <= 4'h0;
            tecla_valida <= 1'b0;
            ocupado      <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt      <= '0;
`endif
        end else begin
            fila_m       <= fila;
            fila_s       <= fila_m;
            tecla_valida <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                        if (fila_s == 4'b0) begin
                            col_idx <= col_next;
                            columna <= 4'b0001 << col_next;
                        end else begin
                            row_idx <= first_row;
                            ocupado <= 1'b1;
                            state   <= DEB_PRESS;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (!row_bit) begin
                        ocupado <= 1'b0;
                        cnt     <= '0;
                        state   <= SCAN;
                    end else if (cnt == DEB_LAST) begin
                        cnt          <= '0;
                        tecla        <= key_code(row_idx, col_idx);
                        tecla_valida <= 1'b1;
                        state        <= HOLD;
`ifdef KEY_REPEAT_EN
                        rep_cnt      <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // Any row activity on the held column restarts release qualification.
                    if (fila_s != 4'b0) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        cnt     <= '0;
                        ocupado <= 1'b0;
                        col_idx <= col_next;
                        columna <= 4'b0001 << col_next;
                        state   <= SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`ifdef KEY_REPEAT_EN
                    if (!row_bit) begin
                        rep_cnt <= '0;
                    end else if (rep_cnt == REP_LAST) begin
                        rep_cnt      <= '0;
                        tecla_valida <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= SCAN;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule
